// File: rtl/rec_fn_pkg.sv
// rtl/rec_fn_pkg.sv - shared constants for the recoded-float to integer converter
package rec_fn_pkg;

  // Rounding modes; 5 and 7 are reserved and fall through to truncation.
  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;
  localparam logic [2:0] RM_ROD = 3'd6;

  // Bit positions inside the 3-bit integer exception flag vector.
  localparam int FLAG_NV = 2;
  localparam int FLAG_OF = 1;
  localparam int FLAG_NX = 0;

  // Top three bits of the recoded exponent that mark the special classes.
  localparam logic [2:0] CLS_ZERO = 3'b000;
  localparam logic [2:0] CLS_INF  = 3'b110;
  localparam logic [2:0] CLS_NAN  = 3'b111;

endpackage

// File: rtl/rec_fn_to_in_round.sv
// rtl/rec_fn_to_in_round.sv - round, negate, overflow detect and saturate an aligned magnitude
module rec_fn_to_in_round
  import rec_fn_pkg::*;
#(
  parameter int INT_WIDTH = 64
) (
  input  logic                 sign,
  input  logic                 is_nan,
  input  logic                 is_inf,
  input  logic                 too_big,
  input  logic [INT_WIDTH-1:0] int_part,
  input  logic                 rnd,
  input  logic                 stk,
  input  logic [2:0]           rm,
  input  logic                 signed_out,
  output logic [INT_WIDTH-1:0] result,
  output logic [2:0]           flags
);

  logic                 inexact;
  logic                 incr;
  logic [INT_WIDTH:0]   mag;
  logic [INT_WIDTH-1:0] mag_lo;
  logic                 ovf;
  logic                 invalid;
  logic                 exc_sign;
  logic [INT_WIDTH-1:0] sat;

  // Round the magnitude, then decide whether the signed result fits the target range.
  always_comb begin
    inexact = rnd | stk;
    case (rm)
      RM_RNE:  incr = rnd & (stk | int_part[0]);
      RM_RMM:  incr = rnd;
      RM_RDN:  incr = sign & inexact;
      RM_RUP:  incr = !sign & inexact;
      default: incr = 1'b0;
    endcase
    mag = {1'b0, int_part} + {{INT_WIDTH{1'b0}}, incr};
    // Round-to-odd jams any lost fraction into the LSB.
    if (rm == RM_ROD) mag[0] = mag[0] | inexact;
    mag_lo = mag[INT_WIDTH-1:0];

    if (signed_out)
      ovf = sign ? (mag[INT_WIDTH] | (mag[INT_WIDTH-1] & (|mag[INT_WIDTH-2:0])))
                 : (mag[INT_WIDTH] | mag[INT_WIDTH-1]);
    else
      ovf = sign ? (|mag) : mag[INT_WIDTH];
    ovf = ovf | too_big;

    invalid  = is_nan | is_inf;
    exc_sign = sign & !is_nan;
    if (signed_out)
      sat = exc_sign ? {1'b1, {(INT_WIDTH-1){1'b0}}} : {1'b0, {(INT_WIDTH-1){1'b1}}};
    else
      sat = exc_sign ? '0 : '1;

    result = (invalid | ovf) ? sat : (sign ? -mag_lo : mag_lo);

    flags          = '0;
    flags[FLAG_NV] = invalid;
    flags[FLAG_OF] = !invalid & ovf;
    flags[FLAG_NX] = !invalid & !ovf & inexact;
  end

endmodule

// File: rtl/rec_fn_to_in_pipe.sv
// rtl/rec_fn_to_in_pipe.sv - pipelined recoded-float to integer converter with handshake and sticky flags
module rec_fn_to_in_pipe
  import rec_fn_pkg::*;
#(
  parameter int EXP_WIDTH = 11,
  parameter int SIG_WIDTH = 53,
  parameter int INT_WIDTH = 64,
  parameter int STAGES    = 2,
  parameter int TAG_WIDTH = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           io_in_valid,
  output logic                           io_in_ready,
  input  logic [EXP_WIDTH+SIG_WIDTH:0]   io_in_bits_in,
  input  logic [2:0]                     io_in_bits_roundingMode,
  input  logic                           io_in_bits_signedOut,
  input  logic [TAG_WIDTH-1:0]           io_in_bits_tag,
  output logic                           io_out_valid,
  input  logic                           io_out_ready,
  output logic [INT_WIDTH-1:0]           io_out_bits_out,
  output logic [2:0]                     io_out_bits_intExceptionFlags,
  output logic [TAG_WIDTH-1:0]           io_out_bits_tag,
  input  logic                           io_flagsClear,
  output logic [2:0]                     io_flagsSticky
);

  localparam int SHW = $clog2(INT_WIDTH);

  logic                       a_sign;
  logic [EXP_WIDTH:0]         a_exp;
  logic [SIG_WIDTH-2:0]       a_fract;
  logic [2:0]                 cls;
  logic                       a_zero, a_inf, a_nan, a_big;
  logic                       ge_one, half_up;
  logic [EXP_WIDTH-1:0]       pos_exp;
  logic [SHW-1:0]             sh;
  logic [SIG_WIDTH+INT_WIDTH-2:0] shifted;
  logic [INT_WIDTH-1:0]       a_int;
  logic                       a_rnd, a_stk;

  assign {a_sign, a_exp, a_fract} = io_in_bits_in;

  // Classify the operand and align its significand so the binary point sits at bit SIG_WIDTH-1.
  always_comb begin
    cls     = a_exp[EXP_WIDTH -: 3];
    a_zero  = (cls == CLS_ZERO);
    a_inf   = (cls == CLS_INF);
    a_nan   = (cls == CLS_NAN);
    ge_one  = a_exp[EXP_WIDTH];
    pos_exp = a_exp[EXP_WIDTH-1:0];
    a_big   = ge_one && (32'(pos_exp) >= INT_WIDTH);
    // 0.5 <= |x| < 1: the round bit is the hidden one itself.
    half_up = !ge_one && (&pos_exp);
    sh      = a_big ? SHW'(INT_WIDTH-1) : pos_exp[SHW-1:0];
    shifted = {{(INT_WIDTH-1){1'b0}}, 1'b1, a_fract} << sh;
    if (ge_one) begin
      a_int = shifted[SIG_WIDTH-1 +: INT_WIDTH];
      a_rnd = shifted[SIG_WIDTH-2];
      a_stk = |shifted[SIG_WIDTH-3:0];
    end else begin
      a_int = '0;
      a_rnd = half_up;
      a_stk = !a_zero && (half_up ? (|a_fract) : 1'b1);
    end
  end

  logic                 v1;
  logic                 adv1;
  logic                 in_ready;
  logic                 r_valid;
  logic                 r_sign, r_nan, r_inf, r_big, r_rnd, r_stk, r_signed;
  logic [INT_WIDTH-1:0] r_int;
  logic [2:0]           r_rm;
  logic [TAG_WIDTH-1:0] r_tag;

  assign adv1        = !v1 | io_out_ready;
  assign io_in_ready = in_ready;

  if (STAGES == 1) begin : g_one
    assign in_ready = adv1;
    assign r_valid  = io_in_valid;
    assign r_sign   = a_sign;
    assign r_nan    = a_nan;
    assign r_inf    = a_inf;
    assign r_big    = a_big;
    assign r_int    = a_int;
    assign r_rnd    = a_rnd;
    assign r_stk    = a_stk;
    assign r_rm     = io_in_bits_roundingMode;
    assign r_signed = io_in_bits_signedOut;
    assign r_tag    = io_in_bits_tag;
  end else begin : g_two
    logic                 v0;
    logic                 s_sign, s_nan, s_inf, s_big, s_rnd, s_stk, s_signed;
    logic [INT_WIDTH-1:0] s_int;
    logic [2:0]           s_rm;
    logic [TAG_WIDTH-1:0] s_tag;

    assign in_ready = !v0 | adv1;

    // Decode/shift register: refills whenever it is empty or its contents move on.
    always_ff @(posedge clock) begin
      if (reset)         v0 <= 1'b0;
      else if (in_ready) v0 <= io_in_valid;
      if (in_ready && io_in_valid) begin
        s_sign   <= a_sign;
        s_nan    <= a_nan;
        s_inf    <= a_inf;
        s_big    <= a_big;
        s_int    <= a_int;
        s_rnd    <= a_rnd;
        s_stk    <= a_stk;
        s_rm     <= io_in_bits_roundingMode;
        s_signed <= io_in_bits_signedOut;
        s_tag    <= io_in_bits_tag;
      end
    end

    assign r_valid  = v0;
    assign r_sign   = s_sign;
    assign r_nan    = s_nan;
    assign r_inf    = s_inf;
    assign r_big    = s_big;
    assign r_int    = s_int;
    assign r_rnd    = s_rnd;
    assign r_stk    = s_stk;
    assign r_rm     = s_rm;
    assign r_signed = s_signed;
    assign r_tag    = s_tag;
  end

  logic [INT_WIDTH-1:0] rnd_result;
  logic [2:0]           rnd_flags;

  rec_fn_to_in_round #(.INT_WIDTH(INT_WIDTH)) u_round (
    .sign       (r_sign),
    .is_nan     (r_nan),
    .is_inf     (r_inf),
    .too_big    (r_big),
    .int_part   (r_int),
    .rnd        (r_rnd),
    .stk        (r_stk),
    .rm         (r_rm),
    .signed_out (r_signed),
    .result     (rnd_result),
    .flags      (rnd_flags)
  );

  logic hs;
  assign hs = v1 & io_out_ready;

  // Output register: holds its contents while the consumer stalls.
  always_ff @(posedge clock) begin
    if (reset)     v1 <= 1'b0;
    else if (adv1) v1 <= r_valid;
    if (adv1 && r_valid) begin
      io_out_bits_out               <= rnd_result;
      io_out_bits_intExceptionFlags <= rnd_flags;
      io_out_bits_tag               <= r_tag;
    end
  end

  assign io_out_valid = v1;

  // Sticky flags: accumulate on hand-off; a clear in the same cycle keeps only that op's flags.
  always_ff @(posedge clock) begin
    if (reset)              io_flagsSticky <= '0;
    else if (io_flagsClear) io_flagsSticky <= hs ? io_out_bits_intExceptionFlags : 3'b000;
    else if (hs)            io_flagsSticky <= io_flagsSticky | io_out_bits_intExceptionFlags;
  end

endmodule

// File: tb/tb_rec_fn_to_in_pipe.sv
// tb/tb_rec_fn_to_in_pipe.sv - self-checking bench for rec_fn_to_in_pipe
module tb_rec_fn_to_in_pipe;
  import rec_fn_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        io_in_valid = 1'b0;
  logic        io_in_ready;
  logic [64:0] io_in_bits_in = '0;
  logic [2:0]  io_in_bits_roundingMode = '0;
  logic        io_in_bits_signedOut = 1'b0;
  logic [3:0]  io_in_bits_tag = '0;
  logic        io_out_valid;
  logic        io_out_ready = 1'b1;
  logic [63:0] io_out_bits_out;
  logic [2:0]  io_out_bits_intExceptionFlags;
  logic [3:0]  io_out_bits_tag;
  logic        io_flagsClear = 1'b0;
  logic [2:0]  io_flagsSticky;

  rec_fn_to_in_pipe dut (
    .clock                         (clock),
    .reset                         (reset),
    .io_in_valid                   (io_in_valid),
    .io_in_ready                   (io_in_ready),
    .io_in_bits_in                 (io_in_bits_in),
    .io_in_bits_roundingMode       (io_in_bits_roundingMode),
    .io_in_bits_signedOut          (io_in_bits_signedOut),
    .io_in_bits_tag                (io_in_bits_tag),
    .io_out_valid                  (io_out_valid),
    .io_out_ready                  (io_out_ready),
    .io_out_bits_out               (io_out_bits_out),
    .io_out_bits_intExceptionFlags (io_out_bits_intExceptionFlags),
    .io_out_bits_tag               (io_out_bits_tag),
    .io_flagsClear                 (io_flagsClear),
    .io_flagsSticky                (io_flagsSticky)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [64:0] in_bits;
    logic [2:0]  rm;
    logic        so;
    logic [63:0] exp_out;
    logic [2:0]  exp_flags;
  } vec_t;

  typedef struct {
    logic [63:0] out;
    logic [2:0]  flags;
    logic [3:0]  tag;
  } exp_t;

  localparam int NV = 27;
  localparam logic [63:0] MAX_S = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN_S = 64'h8000_0000_0000_0000;
  localparam logic [51:0] F_HALF = 52'h8000000000000;
  localparam logic [51:0] F_QTR  = 52'h4000000000000;
  localparam logic [51:0] F_3Q   = 52'hC000000000000;
  localparam logic [51:0] F_0P2  = 52'h3333333333333;

  vec_t vecs[NV];
  exp_t expq[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   last_out_cyc = 0;

  always @(posedge clock) cyc++;

  function automatic logic [64:0] rec(logic s, logic [11:0] e, logic [51:0] f);
    return {s, e, f};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at cyc %0d", name, act, req, cyc);
    end
  endtask

  task automatic setv(int i, logic [64:0] in_bits, logic [2:0] rm, logic so,
                      logic [63:0] eo, logic [2:0] ef);
    vecs[i].in_bits   = in_bits;
    vecs[i].rm        = rm;
    vecs[i].so        = so;
    vecs[i].exp_out   = eo;
    vecs[i].exp_flags = ef;
  endtask

  // Output monitor: every valid cycle must show the oldest outstanding expected result.
  always @(negedge clock) begin
    if (!reset && io_out_valid) begin
      if (expq.size() == 0) begin
        check("spurious_out_valid", 64'(io_out_valid), 64'd0);
      end else begin
        check("out_bits", io_out_bits_out, expq[0].out);
        check("out_flags", 64'(io_out_bits_intExceptionFlags), 64'(expq[0].flags));
        check("out_tag", 64'(io_out_bits_tag), 64'(expq[0].tag));
        if (io_out_ready) begin
          void'(expq.pop_front());
          last_out_cyc = cyc;
        end
      end
    end
  end

  task automatic drive(int i, logic [3:0] tag);
    io_in_bits_in           = vecs[i].in_bits;
    io_in_bits_roundingMode = vecs[i].rm;
    io_in_bits_signedOut    = vecs[i].so;
    io_in_bits_tag          = tag;
    io_in_valid             = 1'b1;
  endtask

  task automatic push(int i, logic [3:0] tag);
    exp_t e;
    e.out   = vecs[i].exp_out;
    e.flags = vecs[i].exp_flags;
    e.tag   = tag;
    expq.push_back(e);
  endtask

  task automatic send_one(int i, logic [3:0] tag);
    bit done = 0;
    drive(i, tag);
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clock);
      if (io_in_ready) begin
        push(i, tag);
        acc_cyc = cyc;
        done = 1;
      end
      @(posedge clock); #1;
    end
    io_in_valid = 1'b0;
    if (!done) check("accept_timeout", 64'(io_in_ready), 64'd1);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 20 && expq.size() != 0; k++) begin
      @(posedge clock); #1;
    end
    check("drain", 64'(expq.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int f;

    setv(0,  rec(0, 12'h801, F_QTR),  RM_RNE, 1, 64'd2, 3'b001);
    setv(1,  rec(0, 12'h801, F_QTR),  RM_RMM, 1, 64'd3, 3'b001);
    setv(2,  rec(0, 12'h801, F_QTR),  RM_ROD, 1, 64'd3, 3'b001);
    setv(3,  rec(1, 12'h83F, '0),     RM_RTZ, 1, MIN_S, 3'b000);
    setv(4,  rec(0, 12'h83F, '0),     RM_RTZ, 1, MAX_S, 3'b010);
    setv(5,  rec(1, 12'h800, '0),     RM_RTZ, 0, 64'd0, 3'b010);
    setv(6,  rec(0, 12'hE00, F_HALF), RM_RNE, 1, MAX_S, 3'b100);
    setv(7,  rec(1, 12'hC00, '0),     RM_RNE, 0, 64'd0, 3'b100);
    setv(8,  rec(1, 12'h7FE, F_0P2),  RM_RTZ, 0, 64'd0, 3'b001);
    setv(9,  rec(1, 12'h7FF, F_0P2),  RM_RNE, 0, 64'd0, 3'b010);
    setv(10, rec(1, 12'h000, '0),     RM_RNE, 1, 64'd0, 3'b000);
    setv(11, rec(1, 12'h000, '0),     RM_RNE, 0, 64'd0, 3'b000);
    setv(12, rec(1, 12'h801, F_QTR),  RM_RDN, 1, 64'hFFFF_FFFF_FFFF_FFFD, 3'b001);
    setv(13, rec(1, 12'h801, F_QTR),  RM_RUP, 1, 64'hFFFF_FFFF_FFFF_FFFE, 3'b001);
    setv(14, rec(0, 12'h801, F_3Q),   RM_RNE, 1, 64'd4, 3'b001);
    setv(15, rec(0, 12'h7FF, '0),     RM_RNE, 1, 64'd0, 3'b001);
    setv(16, rec(0, 12'h7FF, '0),     RM_RMM, 1, 64'd1, 3'b001);
    setv(17, rec(0, 12'h7FE, F_0P2),  RM_RUP, 1, 64'd1, 3'b001);
    setv(18, rec(0, 12'h840, '0),     RM_RTZ, 0, 64'hFFFF_FFFF_FFFF_FFFF, 3'b010);
    setv(19, rec(0, 12'h83F, F_HALF), RM_RTZ, 0, 64'hC000_0000_0000_0000, 3'b000);
    setv(20, rec(0, 12'h801, F_QTR),  3'd5,   1, 64'd2, 3'b001);
    setv(21, rec(1, 12'hC00, '0),     RM_RNE, 1, MIN_S, 3'b100);
    setv(22, rec(0, 12'h801, F_HALF), RM_RNE, 1, 64'd3, 3'b000);
    setv(23, rec(0, 12'h83F, '0),     RM_RTZ, 0, MIN_S, 3'b000);
    setv(24, rec(1, 12'hE00, F_HALF), RM_RNE, 1, MAX_S, 3'b100);
    setv(25, rec(1, 12'h801, F_QTR),  RM_RNE, 0, 64'd0, 3'b010);
    setv(26, rec(0, 12'h7FF, F_HALF), RM_RNE, 0, 64'd1, 3'b001);

    // Reset state.
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check("reset_out_valid", 64'(io_out_valid), 64'd0);
    check("reset_sticky", 64'(io_flagsSticky), 64'd0);
    check("reset_in_ready", 64'(io_in_ready), 64'd1);

    // Table: one op at a time, checking value, flags, tag and two-cycle latency.
    for (int i = 0; i < NV; i++) begin
      send_one(i, 4'(i));
      wait_drain();
      check("latency", 64'(last_out_cyc - acc_cyc), 64'd2);
    end

    // Back-to-back stream of 8 ops with the consumer stalling for 3 cycles.
    idx = 0;
    f = -1;
    for (int c = 0; c < 60; c++) begin
      if (f >= 0) io_out_ready = !(cyc >= f + 4 && cyc <= f + 6);
      if (idx < 8) drive(idx, 4'(idx + 3));
      else io_in_valid = 1'b0;
      @(negedge clock);
      if (io_in_valid && io_in_ready) begin
        push(idx, 4'(idx + 3));
        if (idx == 0) f = cyc;
        idx++;
      end
      @(posedge clock); #1;
      if (idx >= 8 && expq.size() == 0) break;
    end
    io_in_valid  = 1'b0;
    io_out_ready = 1'b1;
    check("stream_accepted", 64'(idx), 64'd8);
    check("stream_drained", 64'(expq.size()), 64'd0);
    check("stream_cycles", 64'(last_out_cyc - f), 64'd12);

    // Sticky accumulation and clear.
    io_flagsClear = 1'b1;
    @(posedge clock); #1;
    io_flagsClear = 1'b0;
    check("sticky_clear_idle", 64'(io_flagsSticky), 64'd0);
    send_one(0, 4'd1);
    wait_drain();
    check("sticky_nx", 64'(io_flagsSticky), 64'b001);
    send_one(4, 4'd2);
    wait_drain();
    check("sticky_nx_of", 64'(io_flagsSticky), 64'b011);
    io_out_ready = 1'b0;
    send_one(6, 4'd3);
    for (int k = 0; k < 10 && !io_out_valid; k++) begin
      @(posedge clock); #1;
    end
    check("sticky_nan_pending", 64'(io_out_valid), 64'd1);
    io_out_ready  = 1'b1;
    io_flagsClear = 1'b1;
    @(posedge clock); #1;
    io_flagsClear = 1'b0;
    check("sticky_clear_with_hs", 64'(io_flagsSticky), 64'b100);
    check("sticky_nan_taken", 64'(expq.size()), 64'd0);

    // Reset with two ops in flight discards both.
    io_out_ready = 1'b0;
    send_one(1, 4'd9);
    send_one(2, 4'd10);
    check("inflight_out_valid", 64'(io_out_valid), 64'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    expq.delete();
    check("midreset_out_valid", 64'(io_out_valid), 64'd0);
    check("midreset_sticky", 64'(io_flagsSticky), 64'd0);
    io_out_ready = 1'b1;
    repeat (6) begin
      @(posedge clock); #1;
    end

    // Pipeline still works after the mid-stream reset.
    send_one(14, 4'd5);
    wait_drain();
    check("post_reset_latency", 64'(last_out_cyc - acc_cyc), 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
